// File: rtl/combo_sequence_detector_pkg.sv
// Shared fighter input definitions: button indices and combo FSM encoding.
// Imported by the combo detector slice.
package fighter_input_pkg;

  localparam int NUM_BTN   = 6;
  localparam int BTN_DOWN  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_PUNCH = 4;
  localparam int BTN_KICK  = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STEP1    = 3'd1,
    ST_STEP2    = 3'd2,
    ST_FIRE     = 3'd3,
    ST_COOLDOWN = 3'd4
  } combo_state_t;

  function automatic logic [1:0] step_progress(combo_state_t s);
    logic [1:0] p;
    p = 2'd0;
    if (s == ST_STEP1) p = 2'd1;
    if (s == ST_STEP2) p = 2'd2;
    return p;
  endfunction

endpackage

// File: rtl/combo_sequence_detector_if.sv
// Button/window bus into a combo detector and its fire/progress outputs.
// master = button side, slave = detector.
interface combo_sequence_detector_if #(
  parameter int NUM_BTN = 6
);

  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_BTN-1:0] window_open;
  logic               combo_fire;
  logic               combo_active;
  logic [1:0]         progress;

  modport master (
    output btn_pulse,
    output window_open,
    input  combo_fire,
    input  combo_active,
    input  progress
  );

  modport slave (
    input  btn_pulse,
    input  window_open,
    output combo_fire,
    output combo_active,
    output progress
  );

endinterface

// File: rtl/combo_sequence_detector_cooldown_timer.sv
// Post-fire cooldown counter: load, count down to zero, hold there.
// done is high whenever the count has reached zero.
module combo_cooldown_timer #(
  parameter  int CYCLES = 8,
  localparam int W      = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [W-1:0] cnt;

  // Load on fire, then decrement without wrapping below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/combo_sequence_detector.sv
// Three-step special-move detector with registered outputs.
// Fires once, then ignores input until the cooldown expires.
module combo_sequence_detector
  import fighter_input_pkg::*;
#(
  parameter int NUM_BTN         = fighter_input_pkg::NUM_BTN,
  parameter int STEP0_BTN       = BTN_DOWN,
  parameter int STEP1_BTN       = BTN_RIGHT,
  parameter int STEP2_BTN       = BTN_PUNCH,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  combo_sequence_detector_if.slave   bus
);

  localparam logic [NUM_BTN-1:0] M0 =
    NUM_BTN'(1) << STEP0_BTN;
  localparam logic [NUM_BTN-1:0] M1 =
    NUM_BTN'(1) << STEP1_BTN;
  localparam logic [NUM_BTN-1:0] M2 =
    NUM_BTN'(1) << STEP2_BTN;

  if (STEP0_BTN >= NUM_BTN ||
      STEP1_BTN >= NUM_BTN ||
      STEP2_BTN >= NUM_BTN) begin : g_cfg_err
    $error("combo step button index out of range");
  end

  combo_state_t       state, nxt;
  logic [NUM_BTN-1:0] exp_mask;
  logic               hit, other, solo0, win_ok;
  logic               tmr_done;
  logic               fire_d, active_d;
  logic [1:0]         prog_d;

  combo_cooldown_timer #(
    .CYCLES (COOLDOWN_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_FIRE),
    .dec   (state == ST_COOLDOWN),
    .done  (tmr_done)
  );

  // State register; reset aborts any combo or cooldown.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next state: window expiry beats a hit, a clean hit beats restart.
  always_comb begin
    exp_mask = M0;
    win_ok   = 1'b1;
    if (state == ST_STEP1) begin
      exp_mask = M1;
      win_ok   = |(bus.window_open & M0);
    end
    if (state == ST_STEP2) begin
      exp_mask = M2;
      win_ok   = |(bus.window_open & M1);
    end
    hit   = |(bus.btn_pulse & exp_mask);
    other = |(bus.btn_pulse & ~exp_mask);
    solo0 = (bus.btn_pulse == M0);
    nxt   = state;
    unique case (state)
      ST_IDLE: begin
        if (hit && !other) nxt = ST_STEP1;
      end
      ST_STEP1, ST_STEP2: begin
        if (!win_ok) begin
          nxt = ST_IDLE;
        end else if (hit && !other) begin
          nxt = (state == ST_STEP1) ? ST_STEP2 : ST_FIRE;
        end else if (other) begin
          nxt = solo0 ? ST_STEP1 : ST_IDLE;
        end
      end
      ST_FIRE:     nxt = ST_COOLDOWN;
      ST_COOLDOWN: if (tmr_done) nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so outputs line up with it.
  always_comb begin
    fire_d   = (nxt == ST_FIRE);
    prog_d   = step_progress(nxt);
    active_d = (prog_d != 2'd0);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.combo_fire   <= 1'b0;
      bus.combo_active <= 1'b0;
      bus.progress     <= 2'd0;
    end else begin
      bus.combo_fire   <= fire_d;
      bus.combo_active <= active_d;
      bus.progress     <= prog_d;
    end
  end

endmodule

// File: tb/tb_combo_sequence_detector.sv
// Directed bench for combo_sequence_detector (cooldown of 8 cycles).
// Inputs change 1 ns after posedge; outputs are checked there too.
module tb_combo_sequence_detector;

  localparam logic [5:0] B0 = 6'b000001;
  localparam logic [5:0] B1 = 6'b000010;
  localparam logic [5:0] B2 = 6'b000100;
  localparam logic [5:0] B3 = 6'b001000;
  localparam logic [5:0] B4 = 6'b010000;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  combo_sequence_detector_if #(.NUM_BTN(6)) bus ();

  combo_sequence_detector #(
    .NUM_BTN         (6),
    .STEP0_BTN       (0),
    .STEP1_BTN       (1),
    .STEP2_BTN       (4),
    .COOLDOWN_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] m);
    bus.btn_pulse = m;
    tick();
    bus.btn_pulse = '0;
  endtask

  task automatic chk(input string tag, input logic f,
                     input logic a, input logic [1:0] p);
    n_assert++;
    assert (bus.combo_fire === f) else begin
      n_fail++;
      $error("FAIL %s fire: got %b expected %b",
             tag, bus.combo_fire, f);
    end
    n_assert++;
    assert (bus.combo_active === a) else begin
      n_fail++;
      $error("FAIL %s active: got %b expected %b",
             tag, bus.combo_active, a);
    end
    n_assert++;
    assert (bus.progress === p) else begin
      n_fail++;
      $error("FAIL %s progress: got %0d expected %0d",
             tag, bus.progress, p);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.btn_pulse   = '0;
    bus.window_open = '0;
    repeat (3) tick();
    chk("reset", 0, 0, 2'd0);
    reset = 1'b0;
    tick();
    chk("post_reset", 0, 0, 2'd0);
    tick();
    chk("post_reset2", 0, 0, 2'd0);

    // happy path with idle gaps between steps
    bus.window_open = 6'b000011;
    pulse(B0);
    chk("hp_s1", 0, 1, 2'd1);
    repeat (2) tick();
    chk("hp_s1_hold", 0, 1, 2'd1);
    pulse(B1);
    chk("hp_s2", 0, 1, 2'd2);
    repeat (3) tick();
    chk("hp_s2_hold", 0, 1, 2'd2);
    pulse(B4);
    chk("hp_fire", 1, 0, 2'd0);

    // repeat the combo inside cooldown: ignored
    pulse(B0);
    chk("cd_b0", 0, 0, 2'd0);
    pulse(B1);
    chk("cd_b1", 0, 0, 2'd0);
    pulse(B4);
    chk("cd_b4", 0, 0, 2'd0);
    repeat (5) tick();
    pulse(B0);
    chk("cd_last_cycle", 0, 0, 2'd0);
    pulse(B0);
    chk("after_cd_s1", 0, 1, 2'd1);
    pulse(B1);
    chk("after_cd_s2", 0, 1, 2'd2);
    pulse(B4);
    chk("second_fire", 1, 0, 2'd0);
    tick();
    chk("second_fire_end", 0, 0, 2'd0);
    repeat (8) tick();

    // window expiry in STEP1
    pulse(B0);
    chk("exp_s1", 0, 1, 2'd1);
    bus.window_open = 6'b000010;
    tick();
    chk("exp_idle", 0, 0, 2'd0);
    bus.window_open = 6'b000011;
    pulse(B1);
    chk("exp_no_adv", 0, 0, 2'd0);

    // pulse and expiry in the same cycle
    pulse(B0);
    bus.window_open = 6'b000010;
    pulse(B1);
    chk("exp_same_cyc", 0, 0, 2'd0);
    bus.window_open = 6'b000011;

    // simultaneous starter plus other in IDLE
    pulse(B0 | B1);
    chk("idle_simul", 0, 0, 2'd0);

    // STEP2 wrong simultaneous input
    pulse(B0);
    pulse(B1);
    chk("w_s2", 0, 1, 2'd2);
    pulse(B4 | B2);
    chk("w_s2_simul", 0, 0, 2'd0);

    // STEP2 starter alone restarts
    pulse(B0);
    pulse(B1);
    pulse(B0);
    chk("w_s2_restart", 0, 1, 2'd1);
    pulse(B0);
    chk("w_s1_restart", 0, 1, 2'd1);
    pulse(B1);
    chk("w_s2_again", 0, 1, 2'd2);
    pulse(B1);
    chk("w_s2_repeat", 0, 0, 2'd0);
    pulse(B0);
    pulse(B3);
    chk("w_s1_other", 0, 0, 2'd0);

    // STEP2 depends only on window 1
    pulse(B0);
    pulse(B1);
    bus.window_open = 6'b000010;
    pulse(B4);
    chk("win1_fire", 1, 0, 2'd0);
    bus.window_open = 6'b000011;
    repeat (10) tick();
    chk("win1_cd_done", 0, 0, 2'd0);

    // reset together with finisher
    pulse(B0);
    pulse(B1);
    chk("rst_s2", 0, 1, 2'd2);
    reset = 1'b1;
    pulse(B4);
    chk("rst_mid", 0, 0, 2'd0);
    reset = 1'b0;
    tick();
    chk("rst_after", 0, 0, 2'd0);
    pulse(B0);
    chk("rst_restart", 0, 1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
